// File: rtl/popcount_classify_seq.sv
// Multi-cycle set-bit classifier: scans a W-bit vector C bits per cycle and
// reports the exact count plus zero / exactly-one / more-than-one flags.
module popcount_classify_seq #(
  parameter int W          = 32,
  parameter int C          = 8,
  parameter int EARLY_EXIT = 1,
  localparam int CNT_W     = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [W-1:0]     in_x,
  input  logic             in_inv,
  output logic             in_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_has_set_0,
  output logic             out_has_set_1,
  output logic             out_has_set_more_than_1,
  output logic             busy
);

  localparam int N     = W / C;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       sreg_q, sreg_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_vld_q, out_vld_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               zero_q, zero_d;
  logic               one_q, one_d;
  logic               more_q, more_d;

  logic [CNT_W-1:0]   chunk_pc;
  logic [CNT_W-1:0]   sum;
  logic [W-1:0]       sreg_shift;
  logic               last_chunk;
  logic               rest_zero;

  // Popcount of the chunk currently at the bottom of the shift register.
  always_comb begin
    chunk_pc = '0;
    for (int i = 0; i < C; i++) begin
      chunk_pc = chunk_pc + CNT_W'(sreg_q[i]);
    end
  end

  // C == W leaves nothing to shift in; spell it out instead of shifting by W.
  generate
    if (C == W) begin : g_single_chunk
      assign sreg_shift = '0;
    end else begin : g_multi_chunk
      assign sreg_shift = {{C{1'b0}}, sreg_q[W-1:C]};
    end
  endgenerate

  assign sum        = acc_q + chunk_pc;
  assign last_chunk = (idx_q == IDX_W'(N - 1));
  assign rest_zero  = (EARLY_EXIT != 0) && (sreg_shift == '0);

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    out_vld_d = out_vld_q;
    out_cnt_d = out_cnt_q;
    zero_d    = zero_q;
    one_d     = one_q;
    more_d    = more_q;

    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          sreg_d  = in_x ^ {W{in_inv}};
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        acc_d  = sum;
        sreg_d = sreg_shift;
        idx_d  = idx_q + IDX_W'(1);
        if (last_chunk || rest_zero) begin
          state_d   = S_DONE;
          out_vld_d = 1'b1;
          out_cnt_d = sum;
          zero_d    = (sum == '0);
          one_d     = (sum == CNT_W'(1));
          // Written as "neither 0 nor 1" so it folds to 0 when W == 1.
          more_d    = (sum != '0) && (sum != CNT_W'(1));
        end
      end
      S_DONE: begin
        if (out_rdy) begin
          state_d   = S_IDLE;
          out_vld_d = 1'b0;
          out_cnt_d = '0;
          zero_d    = 1'b0;
          one_d     = 1'b0;
          more_d    = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        out_vld_d = 1'b0;
        out_cnt_d = '0;
        zero_d    = 1'b0;
        one_d     = 1'b0;
        more_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sreg_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      out_vld_q <= 1'b0;
      out_cnt_q <= '0;
      zero_q    <= 1'b0;
      one_q     <= 1'b0;
      more_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      out_vld_q <= out_vld_d;
      out_cnt_q <= out_cnt_d;
      zero_q    <= zero_d;
      one_q     <= one_d;
      more_q    <= more_d;
    end
  end

  assign in_rdy                  = (state_q == S_IDLE);
  assign busy                    = (state_q != S_IDLE);
  assign out_vld                 = out_vld_q;
  assign out_cnt                 = out_cnt_q;
  assign out_has_set_0           = zero_q;
  assign out_has_set_1           = one_q;
  assign out_has_set_more_than_1 = more_q;

endmodule

// File: tb/tb_popcount_classify_seq.sv
// Runs the classifier with and without early exit side by side on shared
// stimulus and checks count, flags, latency and handshake behaviour.
module tb_popcount_classify_seq;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int N  = W / C;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  logic [W-1:0]  in_x = '0;
  logic          in_inv = 1'b0;
  logic          out_rdy = 1'b0;
  logic          in_rdy [2];
  logic          vld [2];
  logic          busy [2];
  logic          f0 [2];
  logic          f1 [2];
  logic          fm [2];
  logic [CW-1:0] cnt [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Index 0: always full scan; index 1: early exit.
  popcount_classify_seq #(.W(W), .C(C), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x), .in_inv(in_inv),
    .in_rdy(in_rdy[0]), .out_vld(vld[0]), .out_rdy(out_rdy), .out_cnt(cnt[0]),
    .out_has_set_0(f0[0]), .out_has_set_1(f1[0]),
    .out_has_set_more_than_1(fm[0]), .busy(busy[0])
  );

  popcount_classify_seq #(.W(W), .C(C), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x), .in_inv(in_inv),
    .in_rdy(in_rdy[1]), .out_vld(vld[1]), .out_rdy(out_rdy), .out_cnt(cnt[1]),
    .out_has_set_0(f0[1]), .out_has_set_1(f1[1]),
    .out_has_set_more_than_1(fm[1]), .busy(busy[1])
  );

  function automatic int model_cnt(input logic [W-1:0] x, input logic inv);
    return $countones(inv ? ~x : x);
  endfunction

  // Full scan takes N edges; early exit stops at the highest non-zero chunk.
  function automatic int model_lat(input logic [W-1:0] x, input logic inv, input int ee);
    logic [W-1:0] v;
    int hi;
    v  = inv ? ~x : x;
    hi = 1;
    if (ee == 0) return N;
    for (int k = 0; k < N; k++) begin
      if (((v >> (C * k)) & 32'hFF) != 0) hi = k + 1;
    end
    return hi;
  endfunction

  function automatic logic [2:0] model_flags(input int c);
    if (c == 0) return 3'b001;
    if (c == 1) return 3'b010;
    return 3'b100;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [W-1:0] x, input logic inv, input int hold);
    int         lat [2];
    int         ec;
    int         el;
    logic [2:0] ef;
    ec = model_cnt(x, inv);
    ef = model_flags(ec);
    lat[0] = 0;
    lat[1] = 0;

    in_x = x; in_inv = inv; in_vld = 1'b1;
    step();
    in_vld = 1'b0; in_x = $urandom; in_inv = 1'($urandom_range(0, 1));
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({in_rdy[d], busy[d], vld[d]} !== 3'b010) begin
        failures++;
        $display("FAIL accept dut%0d rdy/busy/vld=%b required 010", d, {in_rdy[d], busy[d], vld[d]});
      end
    end

    for (int k = 1; k <= N + 2 && (lat[0] == 0 || lat[1] == 0); k++) begin
      step();
      for (int d = 0; d < 2; d++) if (vld[d] && lat[d] == 0) lat[d] = k;
    end

    for (int d = 0; d < 2; d++) begin
      el = model_lat(x, inv, d);
      checks++;
      if (lat[d] !== el) begin
        failures++;
        $display("FAIL latency dut%0d x=%h inv=%0d got %0d required %0d", d, x, inv, lat[d], el);
      end
      checks++;
      if ({cnt[d], fm[d], f1[d], f0[d]} !== {CW'(ec), ef}) begin
        failures++;
        $display("FAIL result dut%0d x=%h inv=%0d cnt=%0d flags=%b required cnt=%0d flags=%b",
                 d, x, inv, cnt[d], {fm[d], f1[d], f0[d]}, ec, ef);
      end
      checks++;
      if (in_rdy[d] !== 1'b0) begin
        failures++;
        $display("FAIL rdy_while_done dut%0d in_rdy=%b required 0", d, in_rdy[d]);
      end
    end

    for (int h = 0; h < hold; h++) begin
      in_vld = 1'($urandom_range(0, 1));
      in_x   = $urandom;
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({vld[d], in_rdy[d], cnt[d], fm[d], f1[d], f0[d]} !== {2'b10, CW'(ec), ef}) begin
          failures++;
          $display("FAIL hold dut%0d cyc=%0d vld/rdy=%b%b cnt=%0d flags=%b required 10 cnt=%0d flags=%b",
                   d, h, vld[d], in_rdy[d], cnt[d], {fm[d], f1[d], f0[d]}, ec, ef);
        end
      end
    end
    in_vld = 1'b0;

    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vld[d], cnt[d], fm[d], f1[d], f0[d], busy[d], in_rdy[d]} !== {1'b0, CW'(0), 3'b000, 2'b01}) begin
        failures++;
        $display("FAIL drain dut%0d vld=%b cnt=%0d flags=%b busy=%b rdy=%b required 0/0/000/0/1",
                 d, vld[d], cnt[d], {fm[d], f1[d], f0[d]}, busy[d], in_rdy[d]);
      end
    end
    $display("txn x=%h inv=%0d cnt=%0d lat_full=%0d lat_early=%0d hold=%0d", x, inv, ec, lat[0], lat[1], hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vld[d], cnt[d], fm[d], f1[d], f0[d], busy[d], in_rdy[d]} !== {1'b0, CW'(0), 3'b000, 2'b01}) begin
        failures++;
        $display("FAIL reset dut%0d vld=%b cnt=%0d flags=%b busy=%b rdy=%b required 0/0/000/0/1",
                 d, vld[d], cnt[d], {fm[d], f1[d], f0[d]}, busy[d], in_rdy[d]);
      end
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vld[d], busy[d], in_rdy[d]} !== 3'b001) begin
        failures++;
        $display("FAIL post_reset dut%0d vld/busy/rdy=%b required 001", d, {vld[d], busy[d], in_rdy[d]});
      end
    end
  endtask

  task automatic test_zero();
    run_vec(32'h0000_0000, 1'b0, 0);
  endtask

  task automatic test_early_exit();
    run_vec(32'h0000_8000, 1'b0, 0);
    run_vec(32'h0000_0001, 1'b0, 0);
    run_vec(32'h0012_0000, 1'b0, 0);
  endtask

  task automatic test_invert();
    run_vec(32'hFFFF_FFFF, 1'b1, 0);
    run_vec(32'hFFFF_FFFE, 1'b1, 0);
    run_vec(32'h0000_0000, 1'b1, 0);
  endtask

  task automatic test_full_scan();
    run_vec(32'h8000_0001, 1'b0, 0);
    run_vec(32'hFFFF_FFFF, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_vec(32'h00F0_0F01, 1'b0, 3);
    run_vec(32'h4000_0000, 1'b0, 2);
  endtask

  task automatic test_reset_mid_scan();
    in_x = 32'hFFFF_FFFF; in_inv = 1'b0; in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    step();
    step();
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vld[d], busy[d], in_rdy[d], cnt[d]} !== {3'b001, CW'(0)}) begin
        failures++;
        $display("FAIL async_reset dut%0d vld/busy/rdy=%b cnt=%0d required 001 cnt=0",
                 d, {vld[d], busy[d], in_rdy[d]}, cnt[d]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vld[d], busy[d], in_rdy[d]} !== 3'b001) begin
        failures++;
        $display("FAIL reset_release dut%0d vld/busy/rdy=%b required 001", d, {vld[d], busy[d], in_rdy[d]});
      end
    end
    run_vec(32'h0000_0003, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: x = $urandom;
        1: x = 32'h1 << $urandom_range(0, W - 1);
        2: x = $urandom & $urandom & $urandom;
        default: x = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      endcase
      x = x & (32'hFFFF_FFFF >> (C * $urandom_range(0, N - 1)));
      run_vec(x, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_early_exit();
    test_invert();
    test_full_scan();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
